time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_ctrl_pkg.sv | 35 +++
 rtl/time_carry_calc.sv | 50 +++++
 rtl/time_set_ctrl.sv | 127 ++++++++++++
 tb/tb_time_set_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_ctrl_pkg.sv
// Shared encodings and digit limits for the time-set controller and its carry logic.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  // Which field the carry calculator advances this cycle.
  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_SEC  = 2'd1,
    FLD_MIN  = 2'd2,
    FLD_HR   = 2'd3
  } field_e;

  localparam int SU = 0;
  localparam int ST = 1;
  localparam int MU = 2;
  localparam int MT = 3;
  localparam int HU = 4;
  localparam int HT = 5;

  localparam logic [3:0] SU_MAX  = 4'd9;
  localparam logic [3:0] ST_MAX  = 4'd5;
  localparam logic [3:0] MU_MAX  = 4'd9;
  localparam logic [3:0] MT_MAX  = 4'd5;
  localparam logic [3:0] HT_MAX  = 4'd2;
  localparam logic [3:0] HU_WRAP = 4'd3;
  localparam logic [3:0] HU_MAX  = 4'd9;

  localparam logic [5:0] SEC_CLR_MASK = 6'b000011;

endpackage

// File: rtl/time_carry_calc.sv
// Combinational increment/carry chain over the six BCD digits for the selected field.
module time_carry_calc
  import time_ctrl_pkg::*;
(
  input  field_e     fld,
  input  logic [3:0] ht,
  input  logic [3:0] hu,
  input  logic [3:0] mt,
  input  logic [3:0] mu,
  input  logic [3:0] st,
  input  logic [3:0] su,
  output logic [5:0] inc,
  output logic [5:0] clr,
  output logic       day_wrap
);

  logic su_w_s, st_w_s, mu_w_s, mt_w_s, hu_w_s, hr_wrap_s;
  logic en_su_s, en_st_s, en_mu_s, en_mt_s, en_hr_s;

  // Out-of-range digits compare as "at limit" so they wrap and carry.
  assign su_w_s    = (su >= SU_MAX);
  assign st_w_s    = (st >= ST_MAX);
  assign mu_w_s    = (mu >= MU_MAX);
  assign mt_w_s    = (mt >= MT_MAX);
  assign hu_w_s    = (hu >= HU_MAX);
  assign hr_wrap_s = (ht >= HT_MAX) && (hu >= HU_WRAP);

  assign en_su_s = (fld == FLD_SEC);
  assign en_st_s = en_su_s & su_w_s;
  assign en_mu_s = (en_st_s & st_w_s) | (fld == FLD_MIN);
  assign en_mt_s = en_mu_s & mu_w_s;
  // Minute setting wraps 59 -> 00 without touching the hours.
  assign en_hr_s = (en_mt_s & mt_w_s & (fld == FLD_SEC)) | (fld == FLD_HR);

  assign clr[SU] = en_su_s & su_w_s;
  assign inc[SU] = en_su_s & ~su_w_s;
  assign clr[ST] = en_st_s & st_w_s;
  assign inc[ST] = en_st_s & ~st_w_s;
  assign clr[MU] = en_mu_s & mu_w_s;
  assign inc[MU] = en_mu_s & ~mu_w_s;
  assign clr[MT] = en_mt_s & mt_w_s;
  assign inc[MT] = en_mt_s & ~mt_w_s;
  assign clr[HU] = en_hr_s & (hr_wrap_s | hu_w_s);
  assign inc[HU] = en_hr_s & ~hr_wrap_s & ~hu_w_s;
  assign clr[HT] = en_hr_s & hr_wrap_s;
  assign inc[HT] = en_hr_s & ~hr_wrap_s & hu_w_s;

  assign day_wrap = en_hr_s & hr_wrap_s & (fld == FLD_SEC);

endmodule

// File: rtl/time_set_ctrl.sv
// Run/set-mode controller issuing registered inc/clr pulses to external BCD digit counters.
// Optional field blinking is built when TIME_SET_BLINK_EN is defined.
module time_set_ctrl
  import time_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] ht,
  input  logic [3:0] hu,
  input  logic [3:0] mt,
  input  logic [3:0] mu,
  input  logic [3:0] st,
  input  logic [3:0] su,
  output logic [5:0] inc,
  output logic [5:0] clr,
  output logic [1:0] mode,
  output logic [2:0] blank,
  output logic       day_wrap
);

  mode_e      state_r, state_s;
  field_e     fld_s;
  logic       leave_s, busy_s, tick_s, incb_s;
  logic [5:0] calc_inc_s, calc_clr_s, inc_s, clr_s, inc_r, clr_r;
  logic       calc_dw_s, dw_r;
  logic [2:0] blank_s, blank_r;

  // Counters see the pulse only at the next edge, so digits are stale while a pulse is out.
  assign busy_s = |{inc_r, clr_r};
  assign tick_s = tick & ~busy_s;
  assign incb_s = inc_btn & ~busy_s & ~mode_btn;

  // Next mode and which field (if any) advances this cycle.
  always_comb begin
    state_s = state_r;
    fld_s   = FLD_NONE;
    leave_s = 1'b0;
    case (state_r)
      RUN: begin
        if (tick_s) fld_s = FLD_SEC; else fld_s = FLD_NONE;
        if (mode_btn) state_s = SET_HR; else state_s = RUN;
      end
      SET_HR: begin
        if (incb_s) fld_s = FLD_HR; else fld_s = FLD_NONE;
        if (mode_btn) state_s = SET_MIN; else state_s = SET_HR;
      end
      SET_MIN: begin
        if (incb_s) fld_s = FLD_MIN; else fld_s = FLD_NONE;
        if (mode_btn) state_s = RUN; else state_s = SET_MIN;
        leave_s = mode_btn;
      end
      default: begin
        state_s = RUN;
        fld_s   = FLD_NONE;
      end
    endcase
  end

  time_carry_calc u_carry (
    .fld      (fld_s),
    .ht       (ht),
    .hu       (hu),
    .mt       (mt),
    .mu       (mu),
    .st       (st),
    .su       (su),
    .inc      (calc_inc_s),
    .clr      (calc_clr_s),
    .day_wrap (calc_dw_s)
  );

  assign inc_s = calc_inc_s;
  assign clr_s = calc_clr_s | (leave_s ? SEC_CLR_MASK : 6'b000000);

`ifdef TIME_SET_BLINK_EN
  logic phase_r, phase_s;

  // Blink phase toggles on accepted ticks while setting; the selected field follows it.
  always_comb begin
    phase_s = phase_r;
    blank_s = 3'b000;
    if (state_s == RUN) phase_s = 1'b0;
    else if ((state_r != RUN) && tick_s) phase_s = ~phase_r;
    else phase_s = phase_r;
    case (state_s)
      SET_HR:  blank_s = {phase_s, 2'b00};
      SET_MIN: blank_s = {1'b0, phase_s, 1'b0};
      default: blank_s = 3'b000;
    endcase
  end

  // Blink phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_r <= 1'b0;
    else      phase_r <= phase_s;
  end
`else
  assign blank_s = 3'b000;
`endif

  // Mode and registered output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      inc_r   <= 6'b000000;
      clr_r   <= 6'b000000;
      dw_r    <= 1'b0;
      blank_r <= 3'b000;
    end else begin
      state_r <= state_s;
      inc_r   <= inc_s;
      clr_r   <= clr_s;
      dw_r    <= calc_dw_s;
      blank_r <= blank_s;
    end
  end

  assign inc      = inc_r;
  assign clr      = clr_r;
  assign day_wrap = dw_r;
  assign blank    = blank_r;
  assign mode     = state_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: time-of-day reference model plus directed pins.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
  logic [3:0] ht, hu, mt, mu, st, su;
  logic [5:0] inc, clr;
  logic [1:0] mode;
  logic [2:0] blank;
  logic       day_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs during the current cycle, and the decision for the next one.
  logic [5:0] exp_inc, exp_clr, pend_inc, pend_clr;
  logic       exp_dw, pend_dw, exp_phase, pend_phase;
  logic [2:0] exp_blank, pend_blank;
  int         exp_mode, pend_mode;

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .ht(ht), .hu(hu), .mt(mt), .mu(mu), .st(st), .su(su),
    .inc(inc), .clr(clr), .mode(mode), .blank(blank), .day_wrap(day_wrap)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic check_outputs();
    chk("inc",      {2'b00, inc},       {2'b00, exp_inc});
    chk("clr",      {2'b00, clr},       {2'b00, exp_clr});
    chk("day_wrap", {7'd0, day_wrap},   {7'd0, exp_dw});
    chk("blank",    {5'd0, blank},      {5'd0, exp_blank});
    chk("mode",     {6'd0, mode},       8'(exp_mode));
  endtask

  task automatic model_reset();
    exp_inc = 6'd0;  exp_clr = 6'd0;  exp_dw = 1'b0;  exp_blank = 3'd0;
    exp_mode = 0;    exp_phase = 1'b0;
    pend_inc = 6'd0; pend_clr = 6'd0; pend_dw = 1'b0; pend_blank = 3'd0;
    pend_mode = 0;   pend_phase = 1'b0;
  endtask

  // Reference: treat the digits as a time of day, advance it, and report which digits moved.
  task automatic model_decide(input logic t, input logic m, input logic b);
    logic busy, et, eb;
    int   od[6], nd[6];
    int   he, me, se, h2, m2, s2, tt;
    busy = ((exp_inc | exp_clr) != 6'd0);
    et = t & ~busy;
    eb = b & ~busy & ~m;
    od[0] = (su > 9) ? 9 : int'(su);
    od[1] = (st > 5) ? 5 : int'(st);
    od[2] = (mu > 9) ? 9 : int'(mu);
    od[3] = (mt > 5) ? 5 : int'(mt);
    od[5] = (ht > 2) ? 2 : int'(ht);
    od[4] = (hu > 9) ? 9 : int'(hu);
    if (od[5] == 2 && od[4] > 3) od[4] = 3;
    he = od[5] * 10 + od[4];
    me = od[3] * 10 + od[2];
    se = od[1] * 10 + od[0];
    h2 = he; m2 = me; s2 = se;
    pend_inc = 6'd0; pend_clr = 6'd0; pend_dw = 1'b0;
    if (exp_mode == 0 && et) begin
      tt = he * 3600 + me * 60 + se;
      pend_dw = (tt == 86399);
      tt = (tt + 1) % 86400;
      h2 = tt / 3600; m2 = (tt / 60) % 60; s2 = tt % 60;
    end else if (exp_mode == 1 && eb) begin
      h2 = (he + 1) % 24;
    end else if (exp_mode == 2 && eb) begin
      m2 = (me + 1) % 60;
    end
    nd[0] = s2 % 10; nd[1] = s2 / 10;
    nd[2] = m2 % 10; nd[3] = m2 / 10;
    nd[4] = h2 % 10; nd[5] = h2 / 10;
    for (int i = 0; i < 6; i++) begin
      if (nd[i] != od[i]) begin
        if (nd[i] == 0) pend_clr[i] = 1'b1;
        else            pend_inc[i] = 1'b1;
      end
    end
    if (exp_mode == 2 && m) pend_clr = pend_clr | 6'b000011;
    pend_mode = m ? ((exp_mode + 1) % 3) : exp_mode;
    if (pend_mode == 0)              pend_phase = 1'b0;
    else if (exp_mode != 0 && et)    pend_phase = ~exp_phase;
    else                             pend_phase = exp_phase;
`ifdef TIME_SET_BLINK_EN
    if (!pend_phase)         pend_blank = 3'b000;
    else if (pend_mode == 1) pend_blank = 3'b100;
    else                     pend_blank = 3'b010;
`else
    pend_blank = 3'b000;
`endif
  endtask

  function automatic logic [3:0] next_d(input logic [3:0] d, input logic i, input logic c);
    if (c)      return 4'd0;
    else if (i) return d + 4'd1;
    else        return d;
  endfunction

  // External digit counters act on the pulses of the cycle just ended.
  task automatic commit();
    su = next_d(su, exp_inc[0], exp_clr[0]);
    st = next_d(st, exp_inc[1], exp_clr[1]);
    mu = next_d(mu, exp_inc[2], exp_clr[2]);
    mt = next_d(mt, exp_inc[3], exp_clr[3]);
    hu = next_d(hu, exp_inc[4], exp_clr[4]);
    ht = next_d(ht, exp_inc[5], exp_clr[5]);
    exp_inc = pend_inc; exp_clr = pend_clr; exp_dw = pend_dw;
    exp_blank = pend_blank; exp_mode = pend_mode; exp_phase = pend_phase;
  endtask

  // One clock cycle; starts and ends 1 time unit after a rising edge.
  task automatic cyc(input logic t, input logic m, input logic b);
    tick = t; mode_btn = m; inc_btn = b;
    model_decide(t, m, b);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    commit();
  endtask

  task automatic idle_chk();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input int a, input int b, input int c, input int d, input int e, input int f);
    ht = 4'(a); hu = 4'(b); mt = 4'(c); mu = 4'(d); st = 4'(e); su = 4'(f);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    set_raw(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
  endtask

  initial begin
    int since;
    logic t, m, b;
    set_time(0, 0, 0);
    model_reset();
    #1 rst = 1'b0;
    repeat (2) idle_chk();
    rst = 1'b1;
    chk("rst_mode", {6'd0, mode}, 8'd0);
    chk("rst_blank", {5'd0, blank}, 8'd0);

    // Seconds carry into minutes.
    set_time(12, 34, 59);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t1234_clr", {2'b00, clr}, 8'b00000011);
    chk("t1234_inc", {2'b00, inc}, 8'b00000100);
    chk("t1234_model", {2'b00, exp_inc}, 8'b00000100);
    cyc(1'b0, 1'b0, 1'b0);

    // Midnight rollover.
    set_time(23, 59, 59);
    cyc(1'b1, 1'b0, 1'b0);
    chk("day_clr", {2'b00, clr}, 8'b00111111);
    chk("day_inc", {2'b00, inc}, 8'd0);
    chk("day_dw", {7'd0, day_wrap}, 8'd1);
    chk("day_model", {7'd0, exp_dw}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("day_dw_once", {7'd0, day_wrap}, 8'd0);

    // Hour setting wraps 23 -> 00 silently; tick is paused.
    cyc(1'b0, 1'b1, 1'b0);
    chk("sethr_mode", {6'd0, mode}, 8'd1);
    set_time(23, 10, 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("sethr_clr", {2'b00, clr}, 8'b00110000);
    chk("sethr_dw", {7'd0, day_wrap}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("sethr_tick_inc", {2'b00, inc}, 8'd0);
    chk("sethr_tick_clr", {2'b00, clr}, 8'd0);

    // mode_btn beats inc_btn.
    cyc(1'b0, 1'b1, 1'b1);
    chk("modewin_mode", {6'd0, mode}, 8'd2);
    chk("modewin_inc", {2'b00, inc}, 8'd0);
    chk("modewin_clr", {2'b00, clr}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Minute setting wraps 59 -> 00 without hour carry, leaving clears seconds.
    set_time(9, 59, 30);
    cyc(1'b0, 1'b0, 1'b1);
    chk("setmin_clr", {2'b00, clr}, 8'b00001100);
    chk("setmin_inc", {2'b00, inc}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("leave_mode", {6'd0, mode}, 8'd0);
    chk("leave_clr", {2'b00, clr}, 8'b00000011);
    chk("leave_inc", {2'b00, inc}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Back-to-back ticks: the second lands in the busy cycle.
    set_time(1, 2, 3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("tick1_inc", {2'b00, inc}, 8'b00000001);
    cyc(1'b1, 1'b0, 1'b0);
    chk("tick2_inc", {2'b00, inc}, 8'd0);
    chk("tick2_clr", {2'b00, clr}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Out-of-range digits behave as at-limit.
    set_raw(2, 5, 5, 9, 5, 12);
    cyc(1'b1, 1'b0, 1'b0);
    chk("oor_day_clr", {2'b00, clr}, 8'b00111111);
    chk("oor_day_dw", {7'd0, day_wrap}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0);
    set_raw(0, 1, 0, 0, 1, 12);
    cyc(1'b1, 1'b0, 1'b0);
    chk("oor_su_clr", {2'b00, clr}, 8'b00000001);
    chk("oor_su_inc", {2'b00, inc}, 8'b00000010);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset during an issue cycle aborts the pulse at once.
    set_time(10, 0, 0);
    cyc(1'b1, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("arst_inc", {2'b00, inc}, 8'd0);
    chk("arst_clr", {2'b00, clr}, 8'd0);
    model_reset();
    repeat (2) idle_chk();
    rst = 1'b1;
    chk("rel_mode", {6'd0, mode}, 8'd0);
    chk("rel_blank", {5'd0, blank}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rel_inc", {2'b00, inc}, 8'd0);
    chk("rel_clr", {2'b00, clr}, 8'd0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
`ifdef TIME_SET_BLINK_EN
    chk("blink_on", {5'd0, blank}, 8'b00000100);
`else
    chk("blink_on", {5'd0, blank}, 8'd0);
`endif
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("blink_off", {5'd0, blank}, 8'd0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    since = 10;
    for (int k = 0; k < 3000; k++) begin
      if (k % 300 == 0) begin
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        set_time($urandom_range(0, 23), (k % 600 == 0) ? 59 : $urandom_range(0, 59),
                 $urandom_range(55, 59));
        since = 10;
      end
      t = (since >= 2) && ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 24) == 0) && !(t && exp_mode == 0);
      b = ($urandom_range(0, 3) == 0);
      since = t ? 1 : since + 1;
      cyc(t, m, b);
    end
    cyc(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
